lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter LOCK_COUNT, default 3: consecutive correct predictions after the seed sample needed to lock (range 1..15).
REQ-003 Parameter LOSS_COUNT, default 2: consecutive mismatches while locked needed to drop lock (range 1..15).
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 D  input  4  sample from the 4-bit LFSR generator.
REQ-007 VALID  input  1  D is consumed on a rising CLK edge only when VALID=1.
REQ-008 CLR  input  1  synchronous clear of ERR_CNT.
REQ-009 LOCKED  output  1  high in LOCK or SLIP state.
REQ-010 ERR  output  1  registered one-cycle pulse per mismatch detected while locked.
REQ-011 ERR_CNT  output  8  saturating mismatch count.
REQ-012 STATE  output  2  HUNT=00, SYNC=01, LOCK=10, SLIP=11.

Function
REQ-013 The predictor SHALL be next(q) = {q[2:0], q[3]^q[2]}, giving period 15 (0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000); 0000 is illegal.
REQ-014 With VALID=0, state, expected value, counters and ERR_CNT SHALL hold, and ERR SHALL be 0 on the next cycle.
REQ-015 HUNT: on valid D!=0, expected<=next(D), match_cnt<=0, go SYNC; on valid D=0, stay HUNT.
REQ-016 SYNC: on valid D==expected, expected<=next(D) and match_cnt+1; on reaching LOCK_COUNT, go LOCK.
REQ-017 SYNC: on valid mismatch with D!=0, reseed (expected<=next(D), match_cnt<=0, stay SYNC); with D=0, go HUNT. No ERR and no count in SYNC.
REQ-018 LOCK: on valid match, expected<=next(expected). On valid mismatch, ERR=1 next cycle, ERR_CNT+1, miss_cnt<=1, expected<=next(expected) (flywheel), and go SLIP (or HUNT if LOSS_COUNT=1).
REQ-019 SLIP: on valid match, clear miss_cnt and go LOCK. On valid mismatch, ERR pulse, ERR_CNT+1, miss_cnt+1, flywheel; on reaching LOSS_COUNT, go HUNT.
REQ-020 Latency: LOCKED SHALL rise on the edge consuming the (LOCK_COUNT+1)-th consecutive valid in-sequence sample, counting the seed.
REQ-021 ERR_CNT SHALL saturate at 255 and not wrap.
REQ-022 CLR=1 SHALL set ERR_CNT to 0 on the next edge and take priority over a simultaneous increment; ERR SHALL still pulse.
REQ-023 Entering HUNT from SLIP SHALL NOT clear ERR_CNT.
REQ-024 All outputs SHALL be driven directly from registers.

Reset
REQ-025 RST=0 SHALL immediately force STATE=HUNT, LOCKED=0, ERR=0, ERR_CNT=0, and clear expected, match_cnt and miss_cnt, regardless of CLK.
REQ-026 An RST assertion mid-lock SHALL abort tracking. After release, lock SHALL be reacquired only through HUNT and SYNC.

Verification
REQ-027 Reset: hold RST=0 and toggle CLK -> LOCKED=0, ERR=0, ERR_CNT=0, STATE=00; releasing RST changes nothing until a valid sample arrives.
REQ-028 Acquire with defaults: VALID=1, D=0001,0010,0100,1001 -> STATE 00->01->01->01->10; LOCKED=1 after the 4th edge; ERR_CNT=0.
REQ-029 Single error: while locked, expected 0011 but D=0000, then 0110,1101 -> one ERR pulse, ERR_CNT=1, STATE 10->11->10, LOCKED stays 1.
REQ-030 Loss: while locked, two consecutive wrong samples (1111,1111 where 0011,0110 expected) -> ERR pulses twice, ERR_CNT=2, STATE=00, LOCKED=0; a correct stream then reacquires per REQ-028.
REQ-031 Gaps: while locked, VALID=0 for 5 cycles with garbage on D, then resume with the correct next value -> no ERR, STATE stays 10.
REQ-032 Saturation and CLR: force 300 mismatches (LOSS_COUNT=15, relocking as needed) -> ERR_CNT=255. Assert CLR together with a mismatch -> ERR=1, ERR_CNT=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// Tracks a 4-bit LFSR sample stream (x^4+x^3+1, period 15). It locks after enough
// in-sequence samples, then flywheels through errors and reports each one.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] D,
    input  logic       VALID,
    input  logic       CLR,
    output logic       LOCKED,
    output logic       ERR,
    output logic [7:0] ERR_CNT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        SYNC = 2'b01,
        LOCK = 2'b10,
        SLIP = 2'b11
    } state_t;

    localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
    localparam logic [4:0] LOSS_N = 5'(LOSS_COUNT);

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    state_t     state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       locked_q, locked_d;

    logic       err_inc;
    logic [4:0] match_inc;
    logic [4:0] miss_inc;

    assign match_inc = {1'b0, match_cnt_q} + 5'd1;
    assign miss_inc  = {1'b0, miss_cnt_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_inc     = 1'b0;

        if (VALID) begin
            unique case (state_q)
                HUNT: begin
                    if (D != 4'd0) begin
                        exp_d       = lfsr_next(D);
                        match_cnt_d = 4'd0;
                        state_d     = SYNC;
                    end
                end
                SYNC: begin
                    if (D == exp_q) begin
                        exp_d       = lfsr_next(D);
                        match_cnt_d = match_inc[3:0];
                        if (match_inc == LOCK_N) begin
                            miss_cnt_d = 4'd0;
                            state_d    = LOCK;
                        end
                    end else if (D != 4'd0) begin
                        exp_d       = lfsr_next(D);
                        match_cnt_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCK: begin
                    // Expected value free-runs on mismatch so a single bad sample
                    // does not knock us out of phase.
                    exp_d = lfsr_next(exp_q);
                    if (D != exp_q) begin
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        miss_cnt_d = 4'd1;
                        state_d    = (LOSS_N == 5'd1) ? HUNT : SLIP;
                    end
                end
                SLIP: begin
                    exp_d = lfsr_next(exp_q);
                    if (D == exp_q) begin
                        miss_cnt_d = 4'd0;
                        state_d    = LOCK;
                    end else begin
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        miss_cnt_d = miss_inc[3:0];
                        if (miss_inc == LOSS_N) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (CLR) begin
            err_cnt_d = 8'd0;
        end else if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        locked_d = state_d[1];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= HUNT;
            exp_q       <= 4'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
    assign STATE   = state_q;

endmodule
